// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared port indices, packet field slices, XY route and round-robin pick
package mesh_pkg;

  localparam int NUM_PORTS = 5;
  localparam int MAX_PKT_W = 512;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef logic [MAX_PKT_W-1:0] pkt_bus_t;

  // Packets narrower than MAX_PKT_W are zero-extended by the caller.
  function automatic logic [31:0] pkt_dst_x(input pkt_bus_t pkt, input int pkt_w, input int x_w);
    return 32'((pkt >> (pkt_w - x_w)) & ((pkt_bus_t'(1) << x_w) - pkt_bus_t'(1)));
  endfunction

  function automatic logic [31:0] pkt_dst_y(input pkt_bus_t pkt, input int pkt_w, input int x_w,
                                            input int y_w);
    return 32'((pkt >> (pkt_w - x_w - y_w)) & ((pkt_bus_t'(1) << y_w) - pkt_bus_t'(1)));
  endfunction

  function automatic port_e xy_route(input logic [31:0] dst_x, input logic [31:0] dst_y,
                                     input logic [31:0] my_x, input logic [31:0] my_y);
    if (dst_x > my_x) return PORT_EAST;
    if (dst_x < my_x) return PORT_WEST;
    if (dst_y > my_y) return PORT_NORTH;
    if (dst_y < my_y) return PORT_SOUTH;
    return PORT_LOCAL;
  endfunction

  // Returns {found, index}: first request at or after ptr, wrapping 4 -> 0.
  function automatic logic [3:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [2:0] ptr);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[idx]) pick = {1'b1, 3'(idx)};
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-input packet buffer with registered not-full flag
// A written entry becomes visible at the head one cycle after its write.
module router_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_pop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_wr_vis;
  logic [AW:0]      r_rd_ptr;
  logic             r_not_full;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_wr_valid & r_not_full;
  assign w_pop      = i_rd_pop & o_rd_valid;
  assign w_wr_nxt   = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_nxt   = r_rd_ptr + (AW+1)'(w_pop);
  assign w_cnt_nxt  = w_wr_nxt - w_rd_nxt;
  assign o_wr_ready = r_not_full;
  assign o_rd_valid = (r_wr_vis != r_rd_ptr);
  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_wr_vis   <= '0;
      r_rd_ptr   <= '0;
      r_not_full <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_wr_vis   <= r_wr_ptr;
      r_rd_ptr   <= w_rd_nxt;
      r_not_full <= (w_cnt_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/mesh_router.sv
// rtl/mesh_router.sv - 5-port XY mesh router: input FIFOs, per-output RR arbiter and output register
module mesh_router
  import mesh_pkg::*;
#(
  parameter int PKT_W      = 64,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5*PKT_W-1:0] in_data,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  output logic [5*PKT_W-1:0] out_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*16-1:0]    out_count
);

  logic [NUM_PORTS-1:0][PKT_W-1:0]     w_head;
  logic [NUM_PORTS-1:0]                w_head_valid;
  logic [NUM_PORTS-1:0][2:0]           w_route;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0]                w_pop;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    router_fifo #(
      .WIDTH(PKT_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_data (in_data[p*PKT_W +: PKT_W]),
      .i_wr_valid(in_valid[p]),
      .o_wr_ready(in_ready[p]),
      .o_rd_data (w_head[p]),
      .o_rd_valid(w_head_valid[p]),
      .i_rd_pop  (w_pop[p])
    );

    assign w_route[p] = xy_route(pkt_dst_x(MAX_PKT_W'(w_head[p]), PKT_W, X_W),
                                 pkt_dst_y(MAX_PKT_W'(w_head[p]), PKT_W, X_W, Y_W),
                                 32'(MY_X), 32'(MY_Y));
  end

  // Each head routes to exactly one output, so OR-ing the grant rows is conflict free.
  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) w_pop = w_pop | w_grant[o];
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [2:0]           r_ptr;
    logic                 r_valid;
    logic [PKT_W-1:0]     r_data;
    logic [15:0]          r_count;
    logic [NUM_PORTS-1:0] w_req;
    logic [3:0]           w_pick;
    logic [2:0]           w_sel;
    logic                 w_load;
    logic                 w_take;

    always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_PORTS; i++) w_req[i] = w_head_valid[i] && (w_route[i] == 3'(o));
    end

    assign w_pick     = rr_pick(w_req, r_ptr);
    assign w_sel      = w_pick[2:0];
    assign w_load     = !r_valid || out_ready[o];
    assign w_take     = w_pick[3] && w_load;
    assign w_grant[o] = w_take ? (5'd1 << w_sel) : 5'd0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ptr   <= 3'd0;
        r_valid <= 1'b0;
        r_data  <= '0;
        r_count <= 16'd0;
      end else begin
        if (w_take) r_ptr <= (w_sel == 3'd4) ? 3'd0 : w_sel + 3'd1;
        if (w_load) begin
          r_valid <= w_pick[3];
          if (w_pick[3]) r_data <= w_head[w_sel];
        end
        if (r_valid && out_ready[o]) r_count <= r_count + 16'd1;
      end
    end

    assign out_data[o*PKT_W +: PKT_W] = r_data;
    assign out_valid[o]               = r_valid;
    assign out_count[o*16 +: 16]      = r_count;
  end

endmodule

// File: tb/tb_mesh_router.sv
// tb/tb_mesh_router.sv - self-checking bench for mesh_router at node (1,1)
module tb_mesh_router;

  localparam int PKT_W = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [5*PKT_W-1:0] in_data;
  logic [4:0]         in_valid;
  logic [4:0]         in_ready;
  logic [5*PKT_W-1:0] out_data;
  logic [4:0]         out_valid;
  logic [4:0]         out_ready;
  logic [5*16-1:0]    out_count;

  int checks = 0;
  int errors = 0;

  mesh_router #(
    .PKT_W(PKT_W), .X_W(2), .Y_W(2), .FIFO_DEPTH(4), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [59:0] pl(input int src, input int seq);
    return (60'(src) << 12) | 60'(seq & 255);
  endfunction

  function automatic logic [63:0] mk(input int x, input int y, input logic [59:0] payload);
    return {2'(x), 2'(y), payload};
  endfunction

  function automatic logic [63:0] opkt(input int o);
    return out_data[o*PKT_W +: PKT_W];
  endfunction

  function automatic logic [15:0] ocnt(input int o);
    return out_count[o*16 +: 16];
  endfunction

  task automatic set_in(input int p, input logic [63:0] v);
    in_data[p*PKT_W +: PKT_W] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          in_p;
    int          dx;
    int          dy;
    logic [59:0] payload;
    int          exp_o;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    int          exp_cnt[5];
    int          seqn[5];
    int          expn[5];
    bit          pend[5];
    logic [63:0] pkt;
    logic [63:0] prev_data;
    bit          prev_valid;
    bit          prev_ready;
    int          got;
    int          k;
    int          stale;
    int          stab;
    int          sent;
    int          rcv;
    int          order_err;
    int          src;

    vecs[0] = '{0, 3, 1, 60'hAB, 2};
    vecs[1] = '{0, 0, 1, 60'h11, 4};
    vecs[2] = '{0, 1, 3, 60'h22, 1};
    vecs[3] = '{0, 1, 0, 60'h33, 3};
    vecs[4] = '{1, 1, 1, 60'h44, 0};
    vecs[5] = '{2, 2, 0, 60'h55, 2};
    vecs[6] = '{3, 0, 3, 60'h66, 4};
    vecs[7] = '{4, 1, 2, 60'h77, 1};
    vecs[8] = '{2, 1, 0, 60'h88, 3};
    vecs[9] = '{1, 3, 3, 60'h99, 2};

    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 5'h1f;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data_zero", 64'(out_data == '0), 64'h1);
    chk("rst_out_count_zero", 64'(out_count == '0), 64'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h1f);

    // Single packets: routing, exact two-cycle latency and per-output counts.
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
    for (int v = 0; v < 10; v++) begin
      pkt = mk(vecs[v].dx, vecs[v].dy, vecs[v].payload);
      set_in(vecs[v].in_p, pkt);
      in_valid = 5'(1 << vecs[v].in_p);
      chk($sformatf("v%0d_in_ready", v), 64'(in_ready[vecs[v].in_p]), 64'h1);
      @(negedge clk);
      in_valid = '0;
      chk($sformatf("v%0d_lat_n0", v), 64'(out_valid), 64'h0);
      @(negedge clk);
      chk($sformatf("v%0d_lat_n1", v), 64'(out_valid), 64'h0);
      @(negedge clk);
      chk($sformatf("v%0d_route", v), 64'(out_valid), 64'(1 << vecs[v].exp_o));
      chk($sformatf("v%0d_data", v), opkt(vecs[v].exp_o), pkt);
      exp_cnt[vecs[v].exp_o]++;
      @(negedge clk);
      chk($sformatf("v%0d_count", v), 64'(ocnt(vecs[v].exp_o)), 64'(exp_cnt[vecs[v].exp_o]));
      chk($sformatf("v%0d_drained", v), 64'(out_valid), 64'h0);
    end

    // SOUTH and WEST both stream to LOCAL: strict alternation, SOUTH first.
    do_reset();
    for (int i = 0; i < 5; i++) begin seqn[i] = 0; pend[i] = 1'b0; end
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (got > 0) chk("rr_back_to_back", 64'(out_valid[0]), 64'h1);
      if (out_valid[0]) begin
        pkt = opkt(0);
        chk("rr_source", 64'(pkt[15:12]), (got % 2 == 0) ? 64'd3 : 64'd4);
        chk("rr_seq", 64'(pkt[7:0]), 64'(got / 2));
        got++;
      end
      for (int p = 3; p <= 4; p++) begin
        if (pend[p]) seqn[p]++;
        set_in(p, mk(1, 1, pl(p, seqn[p])));
        in_valid[p] = 1'b1;
        pend[p]     = in_ready[p];
      end
      @(negedge clk);
    end
    in_valid = '0;
    chk("rr_total", 64'(got), 64'd10);

    // NORTH stalled: FIFO plus output register absorb five, then drain back-to-back.
    do_reset();
    out_ready = 5'b11101;
    k = 0;
    pend[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (pend[0]) k++;
      if (k < 6) set_in(0, mk(1, 2, pl(0, k)));
      in_valid[0] = (k < 6);
      pend[0]     = in_ready[0] && (k < 6);
      @(negedge clk);
    end
    if (pend[0]) k++;
    in_valid = '0;
    chk("stall_accepted", 64'(k), 64'd5);
    chk("stall_in_ready_low", 64'(in_ready[0]), 64'h0);
    chk("stall_head_valid", 64'(out_valid[1]), 64'h1);
    chk("stall_head_data", opkt(1), mk(1, 2, pl(0, 0)));
    @(negedge clk);
    chk("stall_hold_valid", 64'(out_valid[1]), 64'h1);
    chk("stall_hold_data", opkt(1), mk(1, 2, pl(0, 0)));
    out_ready = 5'h1f;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("drain%0d_valid", j), 64'(out_valid[1]), 64'h1);
      chk($sformatf("drain%0d_data", j), opkt(1), mk(1, 2, pl(0, j)));
      @(negedge clk);
    end
    chk("drain_empty", 64'(out_valid[1]), 64'h0);
    chk("drain_count", 64'(ocnt(1)), 64'd5);

    // Reset while three packets are buffered.
    do_reset();
    out_ready = '0;
    for (int j = 0; j < 3; j++) begin
      set_in(0, mk(1, 2, pl(0, j)));
      in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_buffered", 64'(out_valid[1]), 64'h1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_data_zero", 64'(out_data == '0), 64'h1);
    chk("midrst_count_zero", 64'(out_count == '0), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'h1f);
    out_ready = 5'h1f;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid != 5'h0) stale++;
      @(negedge clk);
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    chk("midrst_count_after", 64'(out_count == '0), 64'h1);

    // 65537 packets on NORTH: counter wraps to 1.
    do_reset();
    out_ready = 5'h1f;
    sent = 0;
    rcv = 0;
    order_err = 0;
    pend[0] = 1'b0;
    for (int c = 0; c < 70000 && rcv < 65537; c++) begin
      if (pend[0]) sent++;
      if (out_valid[1]) begin
        pkt = opkt(1);
        if (pkt[7:0] != 8'(rcv)) order_err++;
        rcv++;
      end
      set_in(0, mk(1, 2, pl(0, sent)));
      in_valid[0] = (sent < 65537);
      pend[0]     = in_ready[0] && (sent < 65537);
      @(negedge clk);
    end
    in_valid = '0;
    chk("wrap_delivered", 64'(rcv), 64'd65537);
    chk("wrap_order", 64'(order_err), 64'd0);
    chk("wrap_count", 64'(ocnt(1)), 64'd1);

    // All inputs to LOCAL with random out_ready: scoreboard per input.
    do_reset();
    for (int i = 0; i < 5; i++) begin seqn[i] = 0; expn[i] = 0; pend[i] = 1'b0; end
    rcv = 0;
    stab = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_data = '0;
    for (int c = 0; c < 3000 && rcv < 60; c++) begin
      out_ready = 5'($urandom_range(0, 31));
      if (prev_valid && !prev_ready && (!out_valid[0] || opkt(0) != prev_data)) stab++;
      if (out_valid[0] && out_ready[0]) begin
        pkt = opkt(0);
        src = int'(pkt[15:12]);
        if (src < 5) begin
          chk($sformatf("sb_order_in%0d", src), 64'(pkt[7:0]), 64'(expn[src]));
          expn[src]++;
        end else begin
          chk("sb_source", 64'(src), 64'd0);
        end
        rcv++;
      end
      prev_valid = out_valid[0];
      prev_ready = out_ready[0];
      prev_data  = opkt(0);
      for (int p = 0; p < 5; p++) begin
        if (pend[p]) seqn[p]++;
        set_in(p, mk(1, 1, pl(p, seqn[p])));
        in_valid[p] = (seqn[p] < 12);
        pend[p]     = in_ready[p] && (seqn[p] < 12);
      end
      @(negedge clk);
    end
    in_valid = '0;
    chk("sb_total", 64'(rcv), 64'd60);
    chk("sb_stable", 64'(stab), 64'd0);
    for (int p = 0; p < 5; p++) chk($sformatf("sb_in%0d_all", p), 64'(expn[p]), 64'd12);
    chk("sb_count", 64'(ocnt(0)), 64'd60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
